lfsr_rng_arbiter: RTL and testbench
===================================

# lfsr_rng_arbiter

Controller that owns one 4-bit Fibonacci LFSR (taps x^4+x^3+1, period 15) and shares its output among NREQ requesters. It handles seeding, zero-seed lock-up protection, warm-up discard after a reseed, and round-robin grant with one fresh pseudo-random word per grant. It sits between the LFSR datapath and the blocks that consume random words, such as test-pattern sources and randomised backoff timers.

## Interface
- NREQ, 4: number of requesters, 2..8.
- SEED_DEFAULT, 4'b0001: LFSR value after reset and substitute for a zero seed; must be nonzero.
- DISCARD, 2: LFSR advances performed after a seed load before serving resumes, 0..15.

- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset; clears all state immediately when low.
- seed_valid  in  1  seed load request.
- seed  in  4  seed value; sampled when seed_valid && seed_ready.
- seed_ready  out  1  combinational; 1 iff state == SERVE.
- req  in  NREQ  per-requester request level.
- gnt  out  NREQ  registered one-hot grant; high for one cycle per issued word.
- rnd  out  4  registered random word; valid while rnd_valid = 1; holds its value otherwise.
- rnd_valid  out  1  registered; equals |gnt.
- busy  out  1  registered; 1 while state == WARM.
- seed_err  out  1  sticky; set when a zero seed is loaded; cleared by the next nonzero seed load or by reset.

## Operation
- Internal LFSR register s[3:0]. Advance: s <= {s[2:0], s[3]^s[2]}. From 0001 it produces 0001, 0010, 0100, 1001, 0011, 0110, 1101, 1010, 0101, 1011, 0111, 1111, 1110, 1100, 1000, 0001, ...
- The LFSR advances only on a grant or during WARM. It holds while idle, so the sequence of issued words is deterministic.
- FSM has two states: SERVE and WARM. A 4-bit counter cnt is used in WARM.
- SERVE, seed_valid = 1:
  - s <= (seed == 0) ? SEED_DEFAULT : seed.
  - seed_err <= (seed == 0).
  - cnt <= DISCARD.
  - Next state is WARM if DISCARD > 0, else SERVE.
  - gnt <= 0. Seed load beats a same-cycle request.
- SERVE, no seed_valid, req != 0:
  - Winner w is the first set req bit at or above ptr, searching cyclically.
  - gnt <= onehot(w), rnd <= s, s <= advance(s), ptr <= (w+1) mod NREQ.
- SERVE, no seed_valid, req == 0: gnt <= 0; s, rnd and ptr hold.
- WARM, each cycle:
  - s <= advance(s), cnt <= cnt-1, gnt <= 0.
  - When cnt == 1, next state is SERVE.
  - seed_valid is ignored (seed_ready = 0). req is ignored and stays pending.
- Requesters hold req until they see gnt. A requester holding req continuously receives one word per NREQ grants under full load.
- Reseeding does not reset ptr.

## Timing
- Reset values:
  - state = SERVE, s = SEED_DEFAULT, ptr = 0, cnt = 0.
  - gnt = 0, rnd = 0, rnd_valid = 0, busy = 0, seed_err = 0.
  - seed_ready = 1 once rst is released.
- Grant latency: req sampled at edge k gives gnt/rnd/rnd_valid valid after edge k, for one cycle. Sustained throughput is one word per cycle.
- Seed to first word: a seed accepted at edge k means busy = 1 for cycles k+1..k+DISCARD. The earliest grant appears after edge k+DISCARD+1, carrying s = advance^DISCARD(seed).
- With DISCARD = 0, the earliest grant appears after edge k+1, and rnd equals the loaded seed.
- Wrap-around: after 15 advances s returns to its starting value; no flag is raised.
- Reset asserted mid-WARM or mid-grant: all outputs drop to their reset values immediately (asynchronous). The first grant after release carries SEED_DEFAULT.
- The all-zero LFSR state is unreachable: reset and zero seeds are both forced to a nonzero value.

## Test plan
- Reset, req = 0001 held for 16 cycles: gnt = 0001 every cycle; rnd = 0001, 0010, 0100, 1001, 0011, ..., 1000, then 0001 on the 16th grant.
- Reset, req = 1111 held for 5 cycles: gnt = 0001, 0010, 0100, 1000, 0001; rnd = 0001, 0010, 0100, 1001, 0011.
- Seed 0110 with DISCARD = 2, and req = 0010 asserted in the same cycle: no gnt that cycle; busy = 1 for 2 cycles; seed_ready = 0 during those cycles; then gnt = 0010 with rnd = 1010.
- Seed 0000 with DISCARD = 2: seed_err = 1; first word = 0100. A following seed of 1000 clears seed_err; first word after it = 0010.
- Reset pulsed low during WARM: gnt, rnd_valid, busy and seed_err all read 0 while rst is low. After release, req = 0100 gets gnt = 0100 with rnd = 0001.
- Idle hold: issue 3 grants (rnd = 0001, 0010, 0100), drop req for 10 cycles, then request again: the next word is 1001 (LFSR did not advance while idle).

Source files
------------

// File: rtl/lfsr_rng_arbiter_if.sv
// Requester-side bundle for lfsr_rng_arbiter: seeding handshake, per-requester
// request/grant lines and the shared random word with its status flags.
interface lfsr_rng_arbiter_if #(
   parameter int NREQ = 4
) ();
   logic            seed_valid;
   logic [3:0]      seed;
   logic            seed_ready;
   logic [NREQ-1:0] req;
   logic [NREQ-1:0] gnt;
   logic [3:0]      rnd;
   logic            rnd_valid;
   logic            busy;
   logic            seed_err;

   modport master (
      output seed_valid, seed, req,
      input  seed_ready, gnt, rnd, rnd_valid, busy, seed_err
   );

   modport slave (
      input  seed_valid, seed, req,
      output seed_ready, gnt, rnd, rnd_valid, busy, seed_err
   );
endinterface

// File: rtl/lfsr_rng_arbiter.sv
// Owns a 4-bit Fibonacci LFSR (x^4+x^3+1) and hands one fresh word per grant
// to NREQ round-robin requesters, with seeding, zero-seed guard and warm-up.
module lfsr_rng_arbiter #(
   parameter int         NREQ         = 4,
   parameter logic [3:0] SEED_DEFAULT = 4'b0001,
   parameter int         DISCARD      = 2
) (
   input logic                  clk,
   input logic                  rst,
   lfsr_rng_arbiter_if.slave    bus
);
   localparam int              PW        = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [3:0]      DISCARD_W = 4'(DISCARD);
   localparam logic [PW-1:0]   LAST      = PW'(NREQ - 1);
   localparam logic [NREQ-1:0] ONE       = {{(NREQ-1){1'b0}}, 1'b1};

   typedef enum logic {SERVE = 1'b0, WARM = 1'b1} state_t;

   state_t          state_r, state_nxt_s;
   logic [3:0]      s_r, s_nxt_s;
   logic [3:0]      cnt_r, cnt_nxt_s;
   logic [PW-1:0]   ptr_r, ptr_nxt_s;
   logic [NREQ-1:0] gnt_r, gnt_nxt_s;
   logic [3:0]      rnd_r, rnd_nxt_s;
   logic            rnd_valid_r;
   logic            busy_r;
   logic            err_r, err_nxt_s;
   logic            found_s;
   logic [PW-1:0]   win_s;
   int              idx_s;

   function automatic logic [3:0] advance(input logic [3:0] v);
      return {v[2:0], v[3] ^ v[2]};
   endfunction

   // Round-robin search: first set request at or above ptr, wrapping around.
   always_comb begin
      found_s = 1'b0;
      win_s   = '0;
      idx_s   = 0;
      for (int i = 0; i < NREQ; i++) begin
         idx_s = (int'(ptr_r) + i) % NREQ;
         if (!found_s && bus.req[idx_s]) begin
            found_s = 1'b1;
            win_s   = PW'(idx_s);
         end else begin
            found_s = found_s;
         end
      end
   end

   // Next-state and next-output logic for the SERVE/WARM controller.
   always_comb begin
      state_nxt_s = state_r;
      s_nxt_s     = s_r;
      cnt_nxt_s   = cnt_r;
      ptr_nxt_s   = ptr_r;
      gnt_nxt_s   = '0;
      rnd_nxt_s   = rnd_r;
      err_nxt_s   = err_r;
      case (state_r)
         SERVE: begin
            if (bus.seed_valid) begin
               // A zero seed would lock the LFSR, so it is replaced and flagged.
               s_nxt_s     = (bus.seed == 4'd0) ? SEED_DEFAULT : bus.seed;
               err_nxt_s   = (bus.seed == 4'd0);
               cnt_nxt_s   = DISCARD_W;
               state_nxt_s = (DISCARD_W != 4'd0) ? WARM : SERVE;
            end else if (found_s) begin
               gnt_nxt_s = ONE << win_s;
               rnd_nxt_s = s_r;
               s_nxt_s   = advance(s_r);
               ptr_nxt_s = (win_s == LAST) ? '0 : win_s + PW'(1);
            end else begin
               gnt_nxt_s = '0;
            end
         end
         WARM: begin
            s_nxt_s     = advance(s_r);
            cnt_nxt_s   = cnt_r - 4'd1;
            state_nxt_s = (cnt_r == 4'd1) ? SERVE : WARM;
         end
         default: begin
            state_nxt_s = SERVE;
         end
      endcase
   end

   // State and registered outputs; async active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= SERVE;
         s_r         <= SEED_DEFAULT;
         cnt_r       <= 4'd0;
         ptr_r       <= '0;
         gnt_r       <= '0;
         rnd_r       <= 4'd0;
         rnd_valid_r <= 1'b0;
         busy_r      <= 1'b0;
         err_r       <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         s_r         <= s_nxt_s;
         cnt_r       <= cnt_nxt_s;
         ptr_r       <= ptr_nxt_s;
         gnt_r       <= gnt_nxt_s;
         rnd_r       <= rnd_nxt_s;
         rnd_valid_r <= |gnt_nxt_s;
         busy_r      <= (state_nxt_s == WARM);
         err_r       <= err_nxt_s;
      end
   end

   assign bus.seed_ready = (state_r == SERVE);
   assign bus.gnt        = gnt_r;
   assign bus.rnd        = rnd_r;
   assign bus.rnd_valid  = rnd_valid_r;
   assign bus.busy       = busy_r;
   assign bus.seed_err   = err_r;
endmodule

// File: tb/tb_lfsr_rng_arbiter.sv
// Directed bench for lfsr_rng_arbiter (NREQ=4, SEED_DEFAULT=0001, DISCARD=2):
// a vector table for the main run plus hand sequences for reset and idle cases.
module tb_lfsr_rng_arbiter;
   logic clk = 1'b0;
   logic rst;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   lfsr_rng_arbiter_if #(.NREQ(4)) bus ();

   lfsr_rng_arbiter #(
      .NREQ(4), .SEED_DEFAULT(4'b0001), .DISCARD(2)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   typedef struct {
      logic       sv;
      logic [3:0] seed;
      logic [3:0] req;
      logic [3:0] gnt;
      logic [3:0] rnd;
      logic       busy;
      logic       rdy;
      logic       err;
   } vec_t;

   vec_t       tbl[$];
   logic [3:0] seq[16];

   task automatic check(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s #%0d: got %h expected %h", nm, idx, act, exp);
      end
   endtask

   task automatic drive(input logic sv, input logic [3:0] sd, input logic [3:0] rq);
      bus.seed_valid = sv;
      bus.seed       = sd;
      bus.req        = rq;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      drive(1'b0, 4'd0, 4'd0);
      rst = 1'b0;
      #1;
      check("rst_gnt",  0, {4'd0, bus.gnt}, 8'd0);
      check("rst_rnd",  0, {4'd0, bus.rnd}, 8'd0);
      check("rst_flags", 0, {5'd0, bus.rnd_valid, bus.busy, bus.seed_err}, 8'd0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst_ready", 0, {7'd0, bus.seed_ready}, 8'd1);
   endtask

   initial begin
      seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1001, 4'b0011, 4'b0110, 4'b1101, 4'b1010,
              4'b0101, 4'b1011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0001};
      // sv, seed, req | gnt, rnd, busy, rdy, err
      for (int i = 0; i < 16; i++)
         tbl.push_back('{1'b0, 4'd0, 4'b0001, 4'b0001, seq[i], 1'b0, 1'b1, 1'b0});
      tbl.push_back('{1'b1, 4'b0110, 4'b0010, 4'b0000, 4'b0001, 1'b1, 1'b0, 1'b0});
      tbl.push_back('{1'b1, 4'b0000, 4'b0010, 4'b0000, 4'b0001, 1'b1, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 4'd0,    4'b0010, 4'b0000, 4'b0001, 1'b0, 1'b1, 1'b0});
      tbl.push_back('{1'b0, 4'd0,    4'b0010, 4'b0010, 4'b1010, 1'b0, 1'b1, 1'b0});
      tbl.push_back('{1'b0, 4'd0,    4'b0000, 4'b0000, 4'b1010, 1'b0, 1'b1, 1'b0});
      tbl.push_back('{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b1010, 1'b1, 1'b0, 1'b1});
      tbl.push_back('{1'b0, 4'd0,    4'b0000, 4'b0000, 4'b1010, 1'b1, 1'b0, 1'b1});
      tbl.push_back('{1'b0, 4'd0,    4'b0000, 4'b0000, 4'b1010, 1'b0, 1'b1, 1'b1});
      tbl.push_back('{1'b0, 4'd0,    4'b0100, 4'b0100, 4'b0100, 1'b0, 1'b1, 1'b1});
      tbl.push_back('{1'b1, 4'b1000, 4'b0000, 4'b0000, 4'b0100, 1'b1, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 4'd0,    4'b0000, 4'b0000, 4'b0100, 1'b1, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 4'd0,    4'b0000, 4'b0000, 4'b0100, 1'b0, 1'b1, 1'b0});
      tbl.push_back('{1'b0, 4'd0,    4'b0100, 4'b0100, 4'b0010, 1'b0, 1'b1, 1'b0});

      do_reset();
      foreach (tbl[i]) begin
         drive(tbl[i].sv, tbl[i].seed, tbl[i].req);
         step();
         check("vec_gnt",   i, {4'd0, bus.gnt}, {4'd0, tbl[i].gnt});
         check("vec_rnd",   i, {4'd0, bus.rnd}, {4'd0, tbl[i].rnd});
         check("vec_flags", i, {4'd0, bus.rnd_valid, bus.busy, bus.seed_ready, bus.seed_err},
               {4'd0, |tbl[i].gnt, tbl[i].busy, tbl[i].rdy, tbl[i].err});
      end

      // Full load round robin, then reset in the middle of a grant.
      do_reset();
      begin
         logic [3:0] eg[5];
         eg = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
         drive(1'b0, 4'd0, 4'b1111);
         for (int i = 0; i < 5; i++) begin
            step();
            check("rr_gnt", i, {4'd0, bus.gnt}, {4'd0, eg[i]});
            check("rr_rnd", i, {4'd0, bus.rnd}, {4'd0, seq[i]});
         end
      end
      #2 rst = 1'b0;
      #1;
      check("midgnt_rst", 0, {bus.gnt, bus.rnd}, 8'd0);
      check("midgnt_rv",  0, {7'd0, bus.rnd_valid}, 8'd0);

      // Reset while warming up after a zero seed.
      do_reset();
      drive(1'b1, 4'b0000, 4'b0000);
      step();
      check("warm_pre", 0, {6'd0, bus.busy, bus.seed_err}, 8'b11);
      drive(1'b0, 4'd0, 4'b0000);
      #2 rst = 1'b0;
      #1;
      check("warm_rst", 0, {4'd0, bus.gnt, bus.rnd_valid, bus.busy, bus.seed_err} & 8'h0f
            | {4'd0, bus.gnt}, 8'd0);
      check("warm_rst_flags", 0, {5'd0, bus.rnd_valid, bus.busy, bus.seed_err}, 8'd0);
      @(negedge clk);
      rst = 1'b1;
      drive(1'b0, 4'd0, 4'b0100);
      step();
      check("post_rst_gnt", 0, {4'd0, bus.gnt}, 8'b0100);
      check("post_rst_rnd", 0, {4'd0, bus.rnd}, 8'b0001);

      // Idle hold: the LFSR must not advance without grants.
      do_reset();
      drive(1'b0, 4'd0, 4'b0001);
      for (int i = 0; i < 3; i++) begin
         step();
         check("idle_pre_rnd", i, {4'd0, bus.rnd}, {4'd0, seq[i]});
      end
      drive(1'b0, 4'd0, 4'b0000);
      for (int i = 0; i < 10; i++) begin
         step();
         check("idle_hold", i, {bus.gnt, bus.rnd}, {4'b0000, 4'b0100});
      end
      drive(1'b0, 4'd0, 4'b0001);
      step();
      check("idle_resume_gnt", 0, {4'd0, bus.gnt}, 8'b0001);
      check("idle_resume_rnd", 0, {4'd0, bus.rnd}, 8'b1001);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
